axi_req_scheduler: RTL and testbench

AXI_REQ_SCHEDULER -- requirements
Module: axi_req_scheduler

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_req_scheduler_if.sv | 33 +++
 rtl/rr_arb2.sv | 14 +
 rtl/axi_req_scheduler.sv | 122 ++++++++++++
 tb/tb_axi_req_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared scheduler state encoding and AXI response codes
package axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/axi_req_scheduler_if.sv
// rtl/axi_req_scheduler_if.sv - requester, AXI master command and channel tap signals
interface axi_req_scheduler_if;
   logic         req0, req1;
   logic         wr0, wr1;
   logic [31:0]  addr0, addr1;
   logic [127:0] wdat0, wdat1;
   logic         gnt0, gnt1;
   logic         done0, done1;
   logic         err0, err1;
   logic [31:0]  rdat;
   logic         m_start;
   logic [31:0]  m_waddr, m_raddr;
   logic [127:0] m_data_in;
   logic         m_bvalid, m_bready, m_rvalid, m_rready, m_rlast;
   logic [1:0]   m_bresp, m_rresp;
   logic [31:0]  m_rdata;

   // scheduler side
   modport master (
      input  req0, req1, wr0, wr1, addr0, addr1, wdat0, wdat1,
      input  m_bvalid, m_bready, m_rvalid, m_rready, m_rlast, m_bresp, m_rresp, m_rdata,
      output gnt0, gnt1, done0, done1, err0, err1, rdat,
      output m_start, m_waddr, m_raddr, m_data_in
   );

   // requesters and AXI master side
   modport slave (
      output req0, req1, wr0, wr1, addr0, addr1, wdat0, wdat1,
      output m_bvalid, m_bready, m_rvalid, m_rready, m_rlast, m_bresp, m_rresp, m_rdata,
      input  gnt0, gnt1, done0, done1, err0, err1, rdat,
      input  m_start, m_waddr, m_raddr, m_data_in
   );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick; ptr names the requester holding priority
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11)
         gnt = ptr ? 2'b10 : 2'b01;
      else
         gnt = req;
   end
endmodule

// File: rtl/axi_req_scheduler.sv
// rtl/axi_req_scheduler.sv - serialises two requesters onto one AXI master command port
module axi_req_scheduler #(
   parameter int TIMEOUT = 256,
   parameter bit RR_INIT = 1'b0
) (
   input  logic                aclk,
   input  logic                areset,
   axi_req_scheduler_if.master bus
);
   import axi_pkg::*;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   sched_state_t state;
   logic         ptr;
   logic         cur;
   logic         wr_q;
   logic [15:0]  cnt;
   logic         err_acc;
   logic [1:0]   pick;
   logic         fin, fin_err, beat, expired;

   rr_arb2 u_arb (
      .req ({bus.req1, bus.req0}),
      .ptr (ptr),
      .gnt (pick)
   );

   // Channel taps only count while waiting, so stray beats never touch rdat/err.
   always_comb begin
      fin     = 1'b0;
      fin_err = err_acc;
      beat    = 1'b0;
      if (state == ST_WAIT) begin
         if (wr_q) begin
            fin     = bus.m_bvalid & bus.m_bready;
            fin_err = err_acc | (fin & resp_is_err(bus.m_bresp));
         end else begin
            beat    = bus.m_rvalid & bus.m_rready;
            fin     = beat & bus.m_rlast;
            fin_err = err_acc | (beat & resp_is_err(bus.m_rresp));
         end
      end
      expired = (state == ST_WAIT) && !fin && (cnt == TO_LAST);
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         state         <= ST_IDLE;
         ptr           <= RR_INIT;
         cur           <= 1'b0;
         wr_q          <= 1'b0;
         cnt           <= '0;
         err_acc       <= 1'b0;
         bus.gnt0      <= 1'b0;
         bus.gnt1      <= 1'b0;
         bus.done0     <= 1'b0;
         bus.done1     <= 1'b0;
         bus.err0      <= 1'b0;
         bus.err1      <= 1'b0;
         bus.rdat      <= '0;
         bus.m_start   <= 1'b0;
         bus.m_waddr   <= '0;
         bus.m_raddr   <= '0;
         bus.m_data_in <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|pick) begin
                  cur           <= pick[1];
                  ptr           <= ~pick[1];
                  wr_q          <= pick[1] ? bus.wr1 : bus.wr0;
                  bus.m_waddr   <= pick[1] ? bus.addr1 : bus.addr0;
                  bus.m_raddr   <= pick[1] ? bus.addr1 : bus.addr0;
                  bus.m_data_in <= pick[1] ? bus.wdat1 : bus.wdat0;
                  bus.m_start   <= 1'b1;
                  bus.gnt0      <= pick[0];
                  bus.gnt1      <= pick[1];
                  if (pick[1]) bus.err1 <= 1'b0;
                  else         bus.err0 <= 1'b0;
                  cnt           <= '0;
                  err_acc       <= 1'b0;
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               bus.m_start <= 1'b0;
               cnt         <= cnt + 16'd1;
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
               if (beat) bus.rdat <= bus.m_rdata;
               err_acc <= fin_err;
               // cnt counts cycles since m_start; reaching TO_LAST aborts.
               if (fin || expired) begin
                  if (cur) begin
                     bus.done1 <= 1'b1;
                     bus.err1  <= fin_err | expired;
                  end else begin
                     bus.done0 <= 1'b1;
                     bus.err0  <= fin_err | expired;
                  end
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_DONE: begin
               bus.done0     <= 1'b0;
               bus.done1     <= 1'b0;
               bus.gnt0      <= 1'b0;
               bus.gnt1      <= 1'b0;
               bus.m_waddr   <= '0;
               bus.m_raddr   <= '0;
               bus.m_data_in <= '0;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_req_scheduler.sv
// tb/tb_axi_req_scheduler.sv - directed self-checking bench for axi_req_scheduler
module tb_axi_req_scheduler;
   logic         aclk   = 1'b0;
   logic         areset = 1'b0;
   int           checks = 0;
   int           errors = 0;
   logic [1:0]   req    = 2'b00;
   logic [1:0]   wr     = 2'b00;
   logic [31:0]  addr [2];
   logic [127:0] wdat [2];
   logic [31:0]  exp_rdat;

   axi_req_scheduler_if bus ();

   assign bus.req0  = req[0];
   assign bus.req1  = req[1];
   assign bus.wr0   = wr[0];
   assign bus.wr1   = wr[1];
   assign bus.addr0 = addr[0];
   assign bus.addr1 = addr[1];
   assign bus.wdat0 = wdat[0];
   assign bus.wdat1 = wdat[1];

   wire [1:0] gnt  = {bus.gnt1, bus.gnt0};
   wire [1:0] done = {bus.done1, bus.done0};
   wire [1:0] err  = {bus.err1, bus.err0};

   axi_req_scheduler #(.TIMEOUT(8), .RR_INIT(1'b0)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_taps();
      bus.m_bvalid = 1'b0; bus.m_bready = 1'b0; bus.m_bresp = 2'b00;
      bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rresp = 2'b00;
      bus.m_rlast  = 1'b0; bus.m_rdata  = 32'h0;
   endtask

   task automatic write_txn(input int idx, input logic [31:0] a, input logic [127:0] d,
                            input logic [1:0] resp, input int stall);
      logic exp_err;
      exp_err   = (resp == 2'b10) || (resp == 2'b11);
      req[idx]  = 1'b1;
      wr[idx]   = 1'b1;
      addr[idx] = a;
      wdat[idx] = d;
      tick();
      check("wr_start", 128'(bus.m_start), 128'(1));
      check("wr_gnt", 128'(gnt), 128'(2'b01 << idx));
      check("wr_waddr", 128'(bus.m_waddr), 128'(a));
      check("wr_data", bus.m_data_in, d);
      check("wr_err_clr", 128'(err[idx]), 128'(0));
      tick();
      check("wr_start_1cyc", 128'(bus.m_start), 128'(0));
      repeat (stall) tick();
      check("wr_raddr_hold", 128'(bus.m_raddr), 128'(a));
      bus.m_bvalid = 1'b1; bus.m_bready = 1'b1; bus.m_bresp = resp;
      tick();
      clear_taps();
      check("wr_done", 128'(done), 128'(2'b01 << idx));
      check("wr_err", 128'(err[idx]), 128'(exp_err));
      check("wr_gnt_done", 128'(gnt), 128'(2'b01 << idx));
      req[idx] = 1'b0;
      tick();
      check("wr_done_pulse", 128'(done), 128'(0));
      check("wr_idle_gnt", 128'(gnt), 128'(0));
      check("wr_idle_addr", 128'(bus.m_waddr), 128'(0));
      check("wr_err_hold", 128'(err[idx]), 128'(exp_err));
   endtask

   task automatic read_txn(input int idx, input logic [31:0] a, input int n, input int bad);
      req[idx]  = 1'b1;
      wr[idx]   = 1'b0;
      addr[idx] = a;
      tick();
      check("rd_start", 128'(bus.m_start), 128'(1));
      check("rd_gnt", 128'(gnt), 128'(2'b01 << idx));
      check("rd_raddr", 128'(bus.m_raddr), 128'(a));
      tick();
      // valid without ready is not a beat: no capture, no error
      bus.m_rvalid = 1'b1; bus.m_rready = 1'b0; bus.m_rdata = 32'hdead_beef; bus.m_rresp = 2'b10;
      tick();
      check("rd_noready", 128'(bus.rdat), 128'(exp_rdat));
      for (int b = 1; b <= n; b++) begin
         bus.m_rready = 1'b1;
         bus.m_rdata  = 32'(b);
         bus.m_rlast  = (b == n);
         bus.m_rresp  = (b == bad) ? 2'b10 : 2'b00;
         tick();
         exp_rdat = 32'(b);
         check("rd_beat", 128'(bus.rdat), 128'(exp_rdat));
         check("rd_done", 128'(done), (b == n) ? 128'(2'b01 << idx) : 128'(0));
      end
      clear_taps();
      check("rd_err", 128'(err[idx]), 128'(bad != 0));
      req[idx] = 1'b0;
      tick();
      check("rd_done_pulse", 128'(done), 128'(0));
   endtask

   initial begin
      clear_taps();
      addr[0] = '0; addr[1] = '0; wdat[0] = '0; wdat[1] = '0;
      exp_rdat = 32'h0;

      tick();
      tick();
      check("rst_gnt", 128'(gnt), 128'(0));
      check("rst_start", 128'(bus.m_start), 128'(0));
      check("rst_rdat", 128'(bus.rdat), 128'(0));
      check("rst_waddr", 128'(bus.m_waddr), 128'(0));
      areset = 1'b1;
      tick();

      write_txn(0, 32'h40, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2'b00, 0);
      read_txn(1, 32'h100, 4, 0);
      check("rd4_rdat", 128'(bus.rdat), 128'(4));

      write_txn(0, 32'h44, 128'h0abc, 2'b10, 2);
      check("err1_untouched", 128'(bus.err1), 128'(0));
      read_txn(1, 32'h104, 2, 1);
      check("err0_untouched", 128'(bus.err0), 128'(1));
      write_txn(0, 32'h48, 128'h0def, 2'b00, 1);
      check("err1_still_set", 128'(bus.err1), 128'(1));

      // stray beats in IDLE
      bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rdata = 32'h55; bus.m_rresp = 2'b11;
      bus.m_rlast  = 1'b1; bus.m_bvalid = 1'b1; bus.m_bready = 1'b1; bus.m_bresp = 2'b11;
      tick();
      tick();
      check("stray_rdat", 128'(bus.rdat), 128'(exp_rdat));
      check("stray_err", 128'(err), 128'(2'b10));
      check("stray_done", 128'(done), 128'(0));
      check("stray_start", 128'(bus.m_start), 128'(0));
      clear_taps();

      // timeout with req dropped mid-transaction
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h200;
      tick();
      check("to_start", 128'(bus.m_start), 128'(1));
      req[0] = 1'b0;
      for (int i = 1; i <= 7; i++) tick();
      check("to_early", 128'(done), 128'(0));
      tick();
      check("to_done", 128'(done), 128'(2'b01));
      check("to_err", 128'(bus.err0), 128'(1));
      check("to_gnt", 128'(gnt), 128'(2'b01));
      tick();
      check("to_pulse", 128'(done), 128'(0));

      // reset while waiting
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h80;
      tick();
      check("rm_err_clr", 128'(bus.err0), 128'(0));
      tick();
      areset = 1'b0;
      #1;
      check("rm_gnt", 128'(gnt), 128'(0));
      check("rm_raddr", 128'(bus.m_raddr), 128'(0));
      check("rm_rdat", 128'(bus.rdat), 128'(0));
      check("rm_err", 128'(err), 128'(0));
      exp_rdat = 32'h0;
      tick();
      check("rm_no_done", 128'(done), 128'(0));
      areset = 1'b1;
      tick();
      check("rm_reissue", 128'(bus.m_start), 128'(1));
      check("rm_regnt", 128'(gnt), 128'(2'b01));
      check("rm_readdr", 128'(bus.m_raddr), 128'(32'h80));
      tick();
      bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'h9;
      tick();
      clear_taps();
      check("rm_done", 128'(done), 128'(2'b01));
      check("rm_rdat9", 128'(bus.rdat), 128'(9));
      req[0] = 1'b0;
      tick();

      // fresh reset, then both requesting: order 0,1,0
      areset = 1'b0;
      tick();
      areset = 1'b1;
      req = 2'b11; wr = 2'b11;
      addr[1] = 32'h300; wdat[1] = 128'h33;
      write_txn(0, 32'h10, 128'h10, 2'b00, 0);
      req[0] = 1'b1;
      write_txn(1, 32'h300, 128'h33, 2'b00, 0);
      write_txn(0, 32'h20, 128'h20, 2'b00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
